databus_axi_read_master: RTL and testbench
==========================================

// Module: databus_axi_read_master
// PURPOSE
//  Upstream feeder for the VRead-style units: serves one databus read request
//  (start address + beat count) by issuing AXI4 INCR read bursts.
//  Returns each data beat to the requester as a databus_ready strobe, and flags
//  the final beat of the whole request with databus_last.
//  Splits requests at MAX_BURST beats and at 4 KB boundaries; one burst outstanding at a time.
// PARAMETERS
//  AXI_ADDR_W  32  byte-address width of databus and AR channel
//  AXI_DATA_W  32  data width (power of 2, >= 32); BYTES = AXI_DATA_W/8
//  LEN_W       8   width of databus_len_i
//  MAX_BURST   16  max beats per AXI burst (power of 2, 1..256)
// PORTS
//  clk              in   1           clock
//  rst              in   1           synchronous active-high reset
//  databus_valid_i  in   1           request valid; held high while requester accepts beats
//  databus_addr_i   in   AXI_ADDR_W  start byte address (low log2(BYTES) bits ignored, treated 0)
//  databus_len_i    in   LEN_W       total beats - 1
//  databus_ready_o  out  1           beat strobe: databus_rdata_o valid this cycle
//  databus_rdata_o  out  AXI_DATA_W  beat data (combinational from m_axi_rdata)
//  databus_last_o   out  1           with ready: final beat of the request
//  m_axi_araddr     out  AXI_ADDR_W  burst start address
//  m_axi_arlen      out  8           burst beats - 1
//  m_axi_arsize     out  3           constant log2(BYTES)
//  m_axi_arburst    out  2           constant 2'b01 (INCR)
//  m_axi_arvalid    out  1           AR valid
//  m_axi_arready    in   1           AR ready
//  m_axi_rdata      in   AXI_DATA_W  R data
//  m_axi_rresp      in   2           R response
//  m_axi_rlast      in   1           R last (informational only)
//  m_axi_rvalid     in   1           R valid
//  m_axi_rready     out  1           R ready
//  busy_o           out  1           state != IDLE
//  error_o          out  1           sticky: any beat had rresp != 0
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge):
//   - state=IDLE; counters cleared; error_o=0.
//   - All AXI valid/ready outputs 0; databus_ready_o=0; databus_last_o=0.
//   - m_axi_araddr and m_axi_arlen = 0.
//   - Reset mid-transfer abandons the request (the AXI slave is reset alongside).
//  FSM IDLE -> ADDR -> DATA -> (ADDR | IDLE):
//   - IDLE: on databus_valid_i=1, capture addr (low bits zeroed) and rem = len+1
//     (LEN_W+1 bits); go to ADDR. Capture also occurs in the cycle right after a
//     previous request's last beat if valid is still high.
//   - ADDR: compute b2k = (4096 - addr[11:0]) >> log2(BYTES) and
//     burst = min(rem, MAX_BURST, b2k). Drive arvalid=1 with araddr/arlen=burst-1
//     from registers; these are stable while arvalid=1 && !arready. On arready,
//     go to DATA and load beat counter = burst.
//   - DATA: m_axi_rready = databus_valid_i (the requester throttles R).
//     A beat transfers on rvalid && rready, giving databus_ready_o=1 in that
//     same cycle (zero latency, no buffering).
//     Per beat: addr += BYTES, rem -= 1, beat counter -= 1.
//     On the burst's final beat: if rem becomes 0, go to IDLE with databus_last_o=1
//     on that beat; else go to ADDR.
//  - Beat count is internal; a m_axi_rlast mismatch is ignored and never alters sequencing.
//  - Any beat with rresp != 0 sets error_o; the transfer continues. error_o clears
//    only on reset or the next IDLE capture.
//  - databus_ready_o is never asserted while databus_valid_i=0. A requester dropping
//    valid mid-burst only stalls R; the request is not cancelled.
//  - Wrap: address increments modulo 2^AXI_ADDR_W. A burst never crosses a 4 KB boundary.
//  - len = 2^LEN_W-1 is legal (rem width LEN_W+1). Requester inputs are sampled only in IDLE.
// TESTING
//  1. addr=0x1000, len=3, slave always ready -> one AR (araddr=0x1000, arlen=3, arsize=2,
//     arburst=1); 4 ready strobes; last on beat 4; busy_o falls the next cycle.
//  2. addr=0x0, len=39, MAX_BURST=16 -> ARs at 0x0/0x40/0x80 with arlen 15/15/7;
//     40 beats; last only on beat 40.
//  3. addr=0x0FF8, len=5 -> AR 0x0FF8 arlen=1, then AR 0x1000 arlen=3; data order preserved.
//  4. Requester drops databus_valid_i for 3 cycles mid-burst, rvalid=1 -> rready=0 and no
//     ready strobes for those 3 cycles; beats resume with no loss or duplication.
//  5. Beat 2 of 4 returns rresp=2'b10 -> error_o=1 from the next cycle; all 4 beats delivered;
//     next request capture clears error_o.
//  6. rst pulsed during DATA of a 16-beat burst -> next cycle IDLE with all outputs 0;
//     a fresh request then completes normally.

Source files
------------

// File: rtl/databus_axi_read_master.sv
// Serves one databus read request (start address + beat count) as a sequence of AXI4 INCR bursts,
// split at MAX_BURST beats and 4 KB boundaries, one burst in flight; beats pass straight through to the requester.
module databus_axi_read_master #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W      = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  databus_valid_i,
  input  logic [AXI_ADDR_W-1:0] databus_addr_i,
  input  logic [LEN_W-1:0]      databus_len_i,
  output logic                  databus_ready_o,
  output logic [AXI_DATA_W-1:0] databus_rdata_o,
  output logic                  databus_last_o,
  output logic [AXI_ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [AXI_DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  busy_o,
  output logic                  error_o
);
  localparam int BYTES = AXI_DATA_W / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam int CW    = (LEN_W + 1 > 13) ? LEN_W + 1 : 13;
  localparam logic [LEN_W:0] REM_ONE = 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                state_q, state_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d, araddr_q, araddr_d;
  logic [LEN_W:0]        rem_q, rem_d;
  logic [8:0]            beat_q, beat_d;
  logic [7:0]            arlen_q, arlen_d;
  logic                  err_q, err_d;
  logic                  load_ar;
  logic                  beat_fire;
  logic                  unused_rlast;

  // Beats available before the next 4 KB page, capped by the remaining count and MAX_BURST.
  function automatic logic [8:0] burst_of(input logic [AXI_ADDR_W-1:0] a, input logic [LEN_W:0] r);
    logic [12:0]   b2k;
    logic [CW-1:0] m;
    b2k = (13'd4096 - {1'b0, a[11:0]}) >> SZ;
    m   = CW'(r);
    if (m > CW'(MAX_BURST)) m = CW'(MAX_BURST);
    if (m > CW'(b2k))       m = CW'(b2k);
    return m[8:0];
  endfunction

  assign beat_fire    = (state_q == DATA) && m_axi_rvalid && databus_valid_i;
  assign unused_rlast = m_axi_rlast;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    beat_d   = beat_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    err_d    = err_q;
    load_ar  = 1'b0;
    case (state_q)
      IDLE: begin
        if (databus_valid_i) begin
          addr_d  = databus_addr_i & ~AXI_ADDR_W'(BYTES - 1);
          rem_d   = (LEN_W + 1)'(databus_len_i) + REM_ONE;
          err_d   = 1'b0;
          state_d = ADDR;
          load_ar = 1'b1;
        end
      end
      ADDR: begin
        if (m_axi_arready) begin
          state_d = DATA;
          beat_d  = {1'b0, arlen_q} + 9'd1;
        end
      end
      DATA: begin
        if (beat_fire) begin
          addr_d = addr_q + AXI_ADDR_W'(BYTES);
          rem_d  = rem_q - REM_ONE;
          beat_d = beat_q - 9'd1;
          if (m_axi_rresp != 2'b00) err_d = 1'b1;
          if (beat_q == 9'd1) begin
            state_d = (rem_q == REM_ONE) ? IDLE : ADDR;
            load_ar = (rem_q != REM_ONE);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // AR fields are registered on entry to ADDR so they hold steady while the slave stalls.
    if (load_ar) begin
      araddr_d = addr_d;
      arlen_d  = 8'(burst_of(addr_d, rem_d) - 9'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      beat_q   <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      beat_q   <= beat_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      err_q    <= err_d;
    end
  end

  assign m_axi_araddr    = araddr_q;
  assign m_axi_arlen     = arlen_q;
  assign m_axi_arsize    = 3'(SZ);
  assign m_axi_arburst   = 2'b01;
  assign m_axi_arvalid   = (state_q == ADDR);
  assign m_axi_rready    = (state_q == DATA) && databus_valid_i;
  assign databus_ready_o = beat_fire;
  assign databus_rdata_o = m_axi_rdata;
  assign databus_last_o  = beat_fire && (rem_q == REM_ONE);
  assign busy_o          = (state_q != IDLE);
  assign error_o         = err_q;
endmodule

// File: tb/tb_databus_axi_read_master.sv
// Randomized scoreboard bench: a burst-splitting reference model fills expected AR/beat queues,
// a reactive AXI slave serves data from an address hash, and a monitor pops and compares.
module tb_databus_axi_read_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        databus_valid_i;
  logic [31:0] databus_addr_i;
  logic [7:0]  databus_len_i;
  logic        databus_ready_o;
  logic [31:0] databus_rdata_o;
  logic        databus_last_o;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic        busy_o;
  logic        error_o;

  databus_axi_read_master dut (
    .clk(clk), .rst(rst),
    .databus_valid_i(databus_valid_i), .databus_addr_i(databus_addr_i), .databus_len_i(databus_len_i),
    .databus_ready_o(databus_ready_o), .databus_rdata_o(databus_rdata_o), .databus_last_o(databus_last_o),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .busy_o(busy_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [31:0] data; bit last; } bt_t;

  ar_t exp_ar[$];
  bt_t exp_bt[$];
  ar_t pend[$];
  int  checks = 0, errors = 0;
  int  ar_pct = 100, r_pct = 100;
  bit  err_en = 0;
  logic [31:0] err_addr = 32'h0;
  int  beats_seen = 0;
  bit  last_seen = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: walk the request page by page, cutting bursts at 16 beats and at each 4 KB page end.
  task automatic model(input logic [31:0] addr, input int len, output bit ee);
    logic [31:0] a;
    int rem, b, b2k;
    ar_t t;
    bt_t d;
    ee = 0;
    a = addr & ~32'd3;
    rem = len + 1;
    while (rem > 0) begin
      b2k = (4096 - int'(a[11:0])) / 4;
      b = rem;
      if (b > 16) b = 16;
      if (b > b2k) b = b2k;
      t.addr = a; t.len = 8'(b - 1);
      exp_ar.push_back(t);
      for (int i = 0; i < b; i++) begin
        d.data = mem(a); d.last = (rem - i == 1);
        exp_bt.push_back(d);
        if (err_en && a == err_addr) ee = 1;
        a = a + 32'd4;
      end
      rem -= b;
    end
  endtask

  // AXI slave: drives at negedge, samples handshakes just after, applies them at the next negedge.
  initial begin
    bit arf, rf;
    int idx;
    ar_t ar_s;
    logic [31:0] ba;
    arf = 0; rf = 0; idx = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend.delete(); idx = 0; arf = 0; rf = 0;
      end else begin
        if (arf) pend.push_back(ar_s);
        if (rf && pend.size() > 0) begin
          idx++;
          if (idx > int'(pend[0].len)) begin
            void'(pend.pop_front());
            idx = 0;
          end
        end
      end
      m_axi_arready = !rst && ($urandom_range(99) < ar_pct);
      if (!rst && pend.size() > 0 && $urandom_range(99) < r_pct) begin
        ba = pend[0].addr + 32'(idx * 4);
        m_axi_rvalid = 1;
        m_axi_rdata  = mem(ba);
        m_axi_rresp  = (err_en && ba == err_addr) ? 2'b10 : 2'b00;
        m_axi_rlast  = (idx == int'(pend[0].len));
      end else begin
        m_axi_rvalid = 0; m_axi_rdata = $urandom; m_axi_rresp = 0; m_axi_rlast = 0;
      end
      #2;
      arf = m_axi_arvalid && m_axi_arready;
      ar_s.addr = m_axi_araddr; ar_s.len = m_axi_arlen;
      rf = m_axi_rvalid && m_axi_rready;
    end
  end

  // Monitor / scoreboard
  initial begin
    bit err_next;
    ar_t ea;
    bt_t eb;
    err_next = 0;
    forever begin
      @(negedge clk);
      #3;
      if (err_next) begin
        chk("error_after_bad_resp", error_o, 1);
        err_next = 0;
      end
      if (!databus_valid_i) chk("strobe_while_invalid", {databus_ready_o, m_axi_rready}, 0);
      if (!rst && m_axi_arvalid && m_axi_arready) begin
        if (exp_ar.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ar: got addr %0h, none expected", m_axi_araddr);
        end else begin
          ea = exp_ar.pop_front();
          chk("araddr", m_axi_araddr, ea.addr);
          chk("arlen", m_axi_arlen, ea.len);
          chk("arsize", m_axi_arsize, 2);
          chk("arburst", m_axi_arburst, 1);
        end
      end
      if (!rst && databus_ready_o) begin
        beats_seen++;
        if (m_axi_rresp != 2'b00) err_next = 1;
        if (exp_bt.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got data %0h, none expected", databus_rdata_o);
        end else begin
          eb = exp_bt.pop_front();
          chk("rdata", databus_rdata_o, eb.data);
          chk("last", databus_last_o, eb.last);
          if (eb.last) last_seen = 1;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1; databus_valid_i = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    exp_ar.delete(); exp_bt.delete();
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_busy"}, busy_o, 0);
    chk({nm, "_outs"}, {m_axi_arvalid, m_axi_rready, databus_ready_o, databus_last_o, error_o}, 0);
    chk({nm, "_ar"}, {m_axi_araddr, m_axi_arlen}, 0);
  endtask

  task automatic start_req(input logic [31:0] addr, input int len, output bit ee);
    model(addr, len, ee);
    beats_seen = 0; last_seen = 0;
    @(negedge clk);
    databus_valid_i = 1; databus_addr_i = addr; databus_len_i = 8'(len);
    @(negedge clk);
    chk("busy_after_capture", busy_o, 1);
    chk("error_clear_on_capture", error_o, 0);
    databus_addr_i = $urandom; databus_len_i = 8'($urandom);
  endtask

  task automatic run_req(input logic [31:0] addr, input int len, input int drop_pct, input int drop_at);
    bit ee, dropped;
    int n;
    start_req(addr, len, ee);
    n = 0; dropped = 0;
    while (!last_seen && n < 4000) begin
      if (drop_at >= 0 && !dropped && beats_seen == drop_at) begin
        databus_valid_i = 0;
        repeat (3) @(negedge clk);
        chk("no_beats_while_dropped", beats_seen, drop_at);
        dropped = 1; n += 3;
        databus_valid_i = 1;
      end else begin
        databus_valid_i = ($urandom_range(99) >= drop_pct);
      end
      @(negedge clk);
      n++;
    end
    databus_valid_i = 0;
    if (!last_seen) begin
      checks++; errors++;
      $display("FAIL request_timeout: addr %0h len %0d, %0d beats seen", addr, len, beats_seen);
      do_reset();
    end else begin
      chk("busy_falls_after_last", busy_o, 0);
      chk("beats_drained", exp_bt.size(), 0);
      chk("ars_drained", exp_ar.size(), 0);
      chk("error_flag", error_o, ee);
    end
  endtask

  initial begin
    bit ee;
    int n, len;
    logic [31:0] a;
    rst = 1; databus_valid_i = 0; databus_addr_i = 0; databus_len_i = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk_idle("reset");

    run_req(32'h0000_1000, 3, 0, -1);
    run_req(32'h0000_0000, 39, 0, -1);
    run_req(32'h0000_0FF8, 5, 0, -1);
    run_req(32'h0000_4000, 7, 0, 2);
    err_en = 1; err_addr = 32'h0000_3004;
    run_req(32'h0000_3000, 3, 0, -1);
    err_en = 0;
    run_req(32'h0000_5000, 1, 0, -1);

    // Reset in the middle of a single 16-beat burst.
    start_req(32'h0000_2000, 15, ee);
    n = 0;
    while (beats_seen < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("beats_before_reset", beats_seen, 5);
    do_reset();
    chk_idle("mid_reset");
    run_req(32'h0000_2000, 15, 0, -1);

    run_req(32'hFFFF_FFF0, 7, 0, -1);
    run_req(32'h0000_1003, 2, 0, -1);
    run_req(32'h0000_7F00, 255, 10, -1);

    for (int i = 0; i < 25; i++) begin
      ar_pct = $urandom_range(100, 30);
      r_pct  = $urandom_range(100, 30);
      a = $urandom;
      if ($urandom_range(1)) a[11:0] = 12'hF00 + 12'($urandom_range(255));
      len = ($urandom_range(9) == 0) ? 255 : $urandom_range(40);
      err_en = ($urandom_range(3) == 0);
      err_addr = (a & ~32'd3) + 32'($urandom_range(len) * 4);
      run_req(a, len, $urandom_range(30), -1);
    end
    err_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
